// File: rtl/sha256_pkg.sv
// Shared constants, types and helpers for the SHA-256 message padder.
// Blocks are stored word 0 first so that word 0 lands in the top 32 bits of the flat bus.
package sha256_pkg;

   localparam int BlockWidth = 512;
   localparam int WordWidth  = 32;
   localparam int LenWidth   = 64;
   localparam int NumWords   = BlockWidth / WordWidth;
   // Byte counter width: the bit-length is the byte count shifted left by 3, modulo 2^64.
   localparam int CntWidth   = LenWidth - 3;

   localparam logic [WordWidth-1:0] PadWord = 32'h8000_0000;

   typedef enum logic [1:0] {
      FILL,
      EMIT,
      EXTRA
   } state_e;

   typedef logic [0:NumWords-1][WordWidth-1:0] block_t;

   // Byte counts above 4 are treated as a full word.
   function automatic logic [2:0] clamp_nbytes(input logic [2:0] nbytes);
      return (nbytes > 3'd4) ? 3'd4 : nbytes;
   endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Word-in / block-out handshake bundle between the message source and the padder.
// The padder takes the slave side; the source (and the consumer of blocks) takes the master side.
interface sha256_padder_if;
   import sha256_pkg::*;

   logic [WordWidth-1:0] in_data_i;
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic                 in_last_i;
   logic [2:0]           in_nbytes_i;
   block_t               blk_o;
   logic                 blk_valid_o;
   logic                 blk_ready_i;
   logic                 blk_first_o;
   logic                 blk_last_o;

   modport slave (
      input  in_data_i, in_valid_i, in_last_i, in_nbytes_i, blk_ready_i,
      output in_ready_o, blk_o, blk_valid_o, blk_first_o, blk_last_o
   );

   modport master (
      output in_data_i, in_valid_i, in_last_i, in_nbytes_i, blk_ready_i,
      input  in_ready_o, blk_o, blk_valid_o, blk_first_o, blk_last_o
   );

endinterface

// File: rtl/sha256_pad_word.sv
// Masks the final message word to its valid bytes and inserts the 0x80 marker when it fits.
// pad_next is set when the word is full, so the marker belongs in the following slot.
module sha256_pad_word
   import sha256_pkg::*;
(
   input  logic [WordWidth-1:0] word,
   input  logic [2:0]           nbytes,
   output logic [WordWidth-1:0] padded,
   output logic                 pad_next
);

   logic [2:0] k;

   always_comb begin
      // NOTE: every output gets a default first, so no path through the loop can infer a latch.
      padded = '0;
      k      = clamp_nbytes(nbytes);
      for (int b = 0; b < 4; b++) begin
         if (3'(b) < k) begin
            padded[31-8*b -: 8] = word[31-8*b -: 8];
         end else if (3'(b) == k) begin
            padded[31-8*b -: 8] = 8'h80;
         end
      end
      pad_next = (k == 3'd4);
   end

endmodule

// File: rtl/sha256_padder.sv
// Packs 32-bit big-endian message words into 512-bit blocks with FIPS 180-4 padding,
// emitting an extra length-only block when the 64-bit length no longer fits.
module sha256_padder
   import sha256_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   sha256_padder_if.slave bus,
   output logic           busy_o
);

   state_e                state_q, state_d;
   block_t                blk_q, fill_last_blk, extra_blk;
   logic [3:0]            widx_q;
   logic [CntWidth-1:0]   cnt_q, cnt_plus;
   logic                  first_pending_q, last_q, extra_pending_q, pad16_q, busy_q;
   logic [WordWidth-1:0]  padded;
   logic                  pad_next, in_ready;
   logic [2:0]            k_eff;
   logic [4:0]            p;
   logic [LenWidth-1:0]   len_fill, len_extra;

   sha256_pad_word u_pad_word (
      .word     (bus.in_data_i),
      .nbytes   (bus.in_nbytes_i),
      .padded   (padded),
      .pad_next (pad_next)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= FILL;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      in_ready        = 1'b0;
      bus.blk_valid_o = 1'b0;
      bus.blk_first_o = 1'b0;
      bus.blk_last_o  = 1'b0;
      unique case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (bus.in_valid_i && (bus.in_last_i || widx_q == 4'd15)) state_d = EMIT;
         end
         EMIT: begin
            bus.blk_valid_o = 1'b1;
            bus.blk_first_o = first_pending_q;
            bus.blk_last_o  = last_q;
            if (bus.blk_ready_i) state_d = (last_q || !extra_pending_q) ? FILL : EXTRA;
         end
         EXTRA:   state_d = EMIT;
         default: state_d = FILL;
      endcase
   end

   // Block images for the final word of a message and for the length-only extra block.
   always_comb begin
      k_eff     = bus.in_last_i ? clamp_nbytes(bus.in_nbytes_i) : 3'd4;
      cnt_plus  = cnt_q + CntWidth'(k_eff);
      len_fill  = {cnt_plus, 3'b000};
      len_extra = {cnt_q, 3'b000};
      p         = {1'b0, widx_q} + {4'b0000, pad_next};

      fill_last_blk = blk_q;
      for (int i = 0; i < NumWords; i++) begin
         if (5'(i) == {1'b0, widx_q}) begin
            fill_last_blk[i] = padded;
         end else if (5'(i) > {1'b0, widx_q}) begin
            fill_last_blk[i] = (5'(i) == p) ? PadWord : '0;
         end
      end
      if (p <= 5'd13) begin
         fill_last_blk[14] = len_fill[63:32];
         fill_last_blk[15] = len_fill[31:0];
      end

      extra_blk     = '0;
      extra_blk[0]  = pad16_q ? PadWord : '0;
      extra_blk[14] = len_extra[63:32];
      extra_blk[15] = len_extra[31:0];
   end

   always_ff @(posedge clk_i) begin
      // NOTE: the block store is reset too, so a message cut short by reset leaves no stale words.
      if (rst_i) begin
         blk_q           <= '0;
         widx_q          <= '0;
         cnt_q           <= '0;
         first_pending_q <= 1'b1;
         last_q          <= 1'b0;
         extra_pending_q <= 1'b0;
         pad16_q         <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every register here sees pre-edge values.
         case (state_q)
            FILL: if (bus.in_valid_i) begin
               busy_q <= 1'b1;
               cnt_q  <= cnt_plus;
               if (bus.in_last_i) begin
                  blk_q           <= fill_last_blk;
                  last_q          <= (p <= 5'd13);
                  extra_pending_q <= (p >= 5'd14);
                  pad16_q         <= (p == 5'd16);
               end else begin
                  blk_q[widx_q]   <= bus.in_data_i;
                  widx_q          <= widx_q + 4'd1;
                  last_q          <= 1'b0;
                  extra_pending_q <= 1'b0;
               end
            end
            EMIT: if (bus.blk_ready_i) begin
               first_pending_q <= last_q;
               if (last_q) begin
                  cnt_q  <= '0;
                  widx_q <= '0;
                  busy_q <= 1'b0;
               end
            end
            EXTRA: begin
               blk_q           <= extra_blk;
               last_q          <= 1'b1;
               extra_pending_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready_o = in_ready;
   assign bus.blk_o      = blk_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: hand-computed padded blocks, flags, latency,
// backpressure stability and mid-message reset.
module tb_sha256_padder;
   import sha256_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   sha256_padder_if bus ();

   sha256_padder dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bus.slave),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required self-termination");
      $fatal(1, "watchdog");
   end

   task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
      int n = 0;
      bus.in_data_i   = d;
      bus.in_last_i   = last;
      bus.in_nbytes_i = nb;
      bus.in_valid_i  = 1'b1;
      while (!bus.in_ready_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL send_word ready: in_ready_o=%b after %0d cycles, required 1", bus.in_ready_o, n);
      end
      @(posedge clk); #1;
      bus.in_valid_i  = 1'b0;
      bus.in_last_i   = 1'b0;
      bus.in_nbytes_i = 3'd0;
   endtask

   task automatic take_block(output block_t b, output logic f, output logic l);
      int n = 0;
      while (!bus.blk_valid_o && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (bus.blk_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL take_block valid: blk_valid_o=%b after %0d cycles, required 1", bus.blk_valid_o, n);
      end
      b = bus.blk_o;
      f = bus.blk_first_o;
      l = bus.blk_last_o;
      bus.blk_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.blk_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_data_i = '0; bus.in_valid_i = 1'b0; bus.in_last_i = 1'b0;
      bus.in_nbytes_i = 3'd0; bus.blk_ready_i = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if ({bus.blk_valid_o, bus.blk_first_o, bus.blk_last_o, busy, bus.in_ready_o} !== 5'b00001) begin
         errors++;
         $display("FAIL reset outputs: valid/first/last/busy/ready=%b, required 00001",
                  {bus.blk_valid_o, bus.blk_first_o, bus.blk_last_o, busy, bus.in_ready_o});
      end
      @(posedge clk); #1;
      checks++;
      if (bus.blk_o !== block_t'('0)) begin
         errors++;
         $display("FAIL reset block: got %h required 0", bus.blk_o);
      end
   endtask

   task automatic test_abc(input string tag);
      block_t b, exp;
      logic f, l;
      exp = '0; exp[0] = 32'h6162_6380; exp[15] = 32'h0000_0018;
      send_word(32'h6162_6300, 1'b1, 3'd3);
      checks++;
      if ({bus.blk_valid_o, busy} !== 2'b11) begin
         errors++;
         $display("FAIL %s latency: valid/busy=%b, required 11", tag, {bus.blk_valid_o, busy});
      end
      take_block(b, f, l);
      checks++;
      if (b !== exp) begin
         errors++;
         $display("FAIL %s block: got %h required %h", tag, b, exp);
      end
      checks++;
      if ({f, l} !== 2'b11) begin
         errors++;
         $display("FAIL %s flags: first/last=%b, required 11", tag, {f, l});
      end
      checks++;
      if ({bus.blk_valid_o, busy, bus.in_ready_o} !== 3'b001) begin
         errors++;
         $display("FAIL %s after handshake: valid/busy/ready=%b, required 001", tag,
                  {bus.blk_valid_o, busy, bus.in_ready_o});
      end
   endtask

   task automatic test_empty();
      block_t b, exp;
      logic f, l;
      exp = '0; exp[0] = PadWord;
      send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
      take_block(b, f, l);
      checks++;
      if (b !== exp || {f, l} !== 2'b11) begin
         errors++;
         $display("FAIL empty block: got %h f/l=%b required %h f/l=11", b, {f, l}, exp);
      end
   endtask

   task automatic test_56();
      block_t b, exp;
      logic f, l;
      exp = '0;
      for (int i = 0; i < 14; i++) begin
         exp[i] = 32'hC0DE_0000 + 32'(i);
         send_word(32'hC0DE_0000 + 32'(i), i == 13, 3'd4);
      end
      exp[14] = PadWord;
      take_block(b, f, l);
      checks++;
      if (b !== exp || {f, l} !== 2'b10) begin
         errors++;
         $display("FAIL len56 block1: got %h f/l=%b required %h f/l=10", b, {f, l}, exp);
      end
      checks++;
      if ({bus.blk_valid_o, busy} !== 2'b01) begin
         errors++;
         $display("FAIL len56 extra gap: valid/busy=%b, required 01", {bus.blk_valid_o, busy});
      end
      @(posedge clk); #1;
      checks++;
      if (bus.blk_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL len56 extra latency: valid=%b, required 1", bus.blk_valid_o);
      end
      exp = '0; exp[15] = 32'h0000_01C0;
      take_block(b, f, l);
      checks++;
      if (b !== exp || {f, l} !== 2'b01) begin
         errors++;
         $display("FAIL len56 block2: got %h f/l=%b required %h f/l=01", b, {f, l}, exp);
      end
   endtask

   task automatic test_fit_boundary();
      block_t b, exp;
      logic f, l;
      exp = '0;
      for (int i = 0; i < 13; i++) begin
         exp[i] = 32'h0F00_0000 + 32'(i);
         send_word(32'h0F00_0000 + 32'(i), 1'b0, 3'd0);
      end
      send_word(32'h1122_3344, 1'b1, 3'd2);
      exp[13] = 32'h1122_8000; exp[15] = 32'h0000_01B0;
      take_block(b, f, l);
      checks++;
      if (b !== exp || {f, l} !== 2'b11) begin
         errors++;
         $display("FAIL fit13 block: got %h f/l=%b required %h f/l=11", b, {f, l}, exp);
      end
   endtask

   task automatic test_64_backpressure();
      block_t b, exp, held;
      logic f, l, hf, hl;
      exp = '0;
      for (int i = 0; i < 16; i++) begin
         exp[i] = 32'h5A5A_0000 + 32'(i);
         send_word(32'h5A5A_0000 + 32'(i), i == 15, 3'd4);
      end
      held = bus.blk_o; hf = bus.blk_first_o; hl = bus.blk_last_o;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.blk_o !== held || {bus.blk_valid_o, bus.blk_first_o, bus.blk_last_o, bus.in_ready_o} !== {1'b1, hf, hl, 1'b0}) begin
            errors++;
            $display("FAIL hold cycle %0d: valid/first/last/ready=%b blk %h, required 1%b%b0 blk %h", c,
                     {bus.blk_valid_o, bus.blk_first_o, bus.blk_last_o, bus.in_ready_o}, hf, hl, bus.blk_o, held);
         end
      end
      take_block(b, f, l);
      checks++;
      if (b !== exp || {f, l} !== 2'b10) begin
         errors++;
         $display("FAIL len64 block1: got %h f/l=%b required %h f/l=10", b, {f, l}, exp);
      end
      exp = '0; exp[0] = PadWord; exp[15] = 32'h0000_0200;
      take_block(b, f, l);
      checks++;
      if (b !== exp || {f, l} !== 2'b01) begin
         errors++;
         $display("FAIL len64 block2: got %h f/l=%b required %h f/l=01", b, {f, l}, exp);
      end
   endtask

   task automatic test_back_to_back();
      block_t b, exp;
      logic f, l;
      test_abc("b2b abc");
      // Non-last nbytes is ignored; nbytes 7 on the last word counts as 4.
      send_word(32'h6162_6364, 1'b0, 3'd0);
      send_word(32'h6566_6768, 1'b1, 3'd7);
      exp = '0; exp[0] = 32'h6162_6364; exp[1] = 32'h6566_6768; exp[2] = PadWord; exp[15] = 32'h0000_0040;
      take_block(b, f, l);
      checks++;
      if (b !== exp || {f, l} !== 2'b11) begin
         errors++;
         $display("FAIL b2b msg2: got %h f/l=%b required %h f/l=11", b, {f, l}, exp);
      end
      send_word(32'hAABB_CCDD, 1'b1, 3'd1);
      exp = '0; exp[0] = 32'hAA80_0000; exp[15] = 32'h0000_0008;
      take_block(b, f, l);
      checks++;
      if (b !== exp || {f, l} !== 2'b11) begin
         errors++;
         $display("FAIL b2b msg3: got %h f/l=%b required %h f/l=11", b, {f, l}, exp);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) send_word(32'h7777_0000 + 32'(i), 1'b0, 3'd4);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midreset busy before: busy=%b, required 1", busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({bus.blk_valid_o, busy, bus.in_ready_o} !== 3'b001) begin
         errors++;
         $display("FAIL midreset outputs: valid/busy/ready=%b, required 001",
                  {bus.blk_valid_o, busy, bus.in_ready_o});
      end
      test_abc("midreset abc");
   endtask

   initial begin
      test_reset();
      test_abc("abc");
      test_empty();
      test_56();
      test_fit_boundary();
      test_64_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
Upstream message-preparation stage for sha256_core. It accepts a message as a stream of 32-bit big-endian words and packs them into 512-bit blocks. It applies FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit message bit-length. It emits each block with a valid/ready handshake, plus first/last flags so the core knows when to initialise and when to finalise its hash state.

Parameters:
BlockWidth, 512, output block width; only 512 is supported.
WordWidth, 32, input word width; only 32 is supported.
LenWidth, 64, width of the appended bit-length field.

Ports:
clk_i  input  1  clock; all logic is on the rising edge.
rst_i  input  1  reset, synchronous, active-high.
in_data_i  input  32  message word, big-endian; byte 0 is in [31:24].
in_valid_i  input  1  in_data_i is valid.
in_ready_o  output  1  padder accepts a word this cycle.
in_last_i  input  1  this word is the final word of the message.
in_nbytes_i  input  3  number of valid bytes in the word, 0..4; only meaningful when in_last_i=1.
blk_o  output  512  block; word 0 is in [511:480], word 15 is in [31:0].
blk_valid_o  output  1  blk_o is valid.
blk_ready_i  input  1  consumer takes the block.
blk_first_o  output  1  block is the first block of its message; qualified by blk_valid_o.
blk_last_o  output  1  block is the final padded block of its message; qualified by blk_valid_o.
busy_o  output  1  a message is in progress: words have been accepted, or a block is pending.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=FILL, word index widx=0, byte counter=0, first_pending=1.
  - All block words cleared.
  - Outputs: blk_valid_o=0, blk_first_o=0, blk_last_o=0, busy_o=0, in_ready_o=1 from the first cycle after reset.
  - Reset mid-message discards all partial data and any pending block without emitting it.
- Input transfer: occurs when in_valid_i & in_ready_o. in_ready_o=1 only in FILL.
- Non-last word:
  - Written into slot widx; widx increments; byte counter += 4.
  - in_nbytes_i is ignored (treated as 4).
- Last word, k = in_nbytes_i (values 5..7 are treated as 4):
  - Bytes 0..k-1 are kept and the remaining bytes are zeroed.
  - If k<4, byte k is set to 0x80 and the pad slot p = widx.
  - If k=4, p = widx+1.
  - k=0 with in_last_i=1 is legal and encodes "no further bytes"; this is how an empty message is sent.
  - Byte counter += k.
- Pad slot within the block (p<=15):
  - If k=4, slot p is written with 0x80000000.
  - Slots above p through 15 are zero.
- Length fit check:
  - If p<=13: slots 14..15 are set to {bytecount,3'b000} (LenWidth bits, modulo 2^64), and the block is emitted with last=1.
  - If p>=14: the current block is emitted with last=0, and state EXTRA is entered.
- Full block: when slot 15 is written by a non-last word, the block is emitted with last=0 and widx wraps to 0.
- EXTRA: after the previous block is accepted, one more block is built. Slot 0 = 0x80000000 if p=16, else 0. Slots 1..13 = 0. Slots 14..15 = length. It is emitted with last=1.
- States and transitions:
  - FILL -> EMIT on a full block or a last word.
  - EMIT -> FILL on blk_ready_i, when last=1 or no EXTRA is pending.
  - EMIT -> EXTRA on blk_ready_i, when EXTRA is pending.
  - EXTRA -> EMIT after 1 cycle, which builds the block.
- Latency:
  - blk_valid_o rises the cycle after the word that completes a block is accepted.
  - The EXTRA block's valid rises 2 cycles after the previous block's handshake.
- Output hold: while blk_valid_o & ~blk_ready_i, blk_o, blk_first_o and blk_last_o are held stable.
- Handshake: blk_valid_o drops the cycle after the handshake; there is no back-to-back emission.
- First flag:
  - blk_first_o = first_pending.
  - first_pending clears on the handshake of any block and sets again on the handshake of a block with last=1.
  - An EXTRA block therefore never has first=1.
- End of message: after a last=1 handshake, the byte counter and widx clear and the next message starts fresh.
- busy_o=1 from the first accepted word until the last=1 handshake.

Decomposition:
- sha256_pkg holds:
  - BlockWidth, WordWidth, LenWidth.
  - The pad constant 32'h8000_0000.
  - The state enum {FILL, EMIT, EXTRA}.
- One combinational sub-module, sha256_pad_word: inputs are a word and k; outputs are the masked/padded word and a pad_next flag.
- The padder drives sha256_core's block input directly.

Test Plan:
1. "abc": 0x61626300, nbytes=3, last -> one block:
   - word0 0x61626380, words1-14 0, word15 0x00000018.
   - first=1, last=1.
2. Empty message: nbytes=0, last, with no other words -> one block:
   - word0 0x80000000, all other words 0.
   - first=1, last=1.
3. 56-byte message: 14 full words, last nbytes=4 -> two blocks:
   - Block 1: word14 0x80000000, word15 0, first=1, last=0.
   - Block 2: words0-14 0, word15 0x000001C0, first=0, last=1.
4. 64-byte message: 16 words, last on word 15 -> two blocks:
   - Block 1: raw data, first=1, last=0.
   - Block 2: word0 0x80000000, word15 0x00000200, last=1.
5. Backpressure: blk_ready_i held low 5 cycles with block 1 pending -> blk_o and flags stable, in_ready_o=0, no words lost; a 2-message back-to-back run shows first=1 again on message 2.
6. rst_i asserted after 7 words of a message -> next cycle blk_valid_o=0, busy_o=0, in_ready_o=1; a subsequent "abc" message reproduces scenario 1 exactly.
